// File: rtl/quad_decoder_cnt.sv
// quad_decoder_cnt: quadrature decoder for asynchronous A/B phase inputs.
// Each phase is synchronized and then filtered. Accepted transitions drive a
// loadable position counter with modulo-2^DWIDTH wrap. Illegal double-bit
// transitions raise a one-cycle error pulse and a sticky error flag.
module quad_decoder_cnt #(
    parameter int DWIDTH        = 16,
    parameter int FILTER_LEN    = 3,
    parameter int DEFAULT_COUNT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              qa,
    input  logic              qb,
    input  logic              cntrl__ena,
    input  logic              cntrl__load,
    input  logic [DWIDTH-1:0] cntrl__data_in,
    input  logic              err_clr,
    output logic              cntrl__up_dwn,
    output logic              step,
    output logic [DWIDTH-1:0] count,
    output logic              err,
    output logic              err_sticky
);

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [3:0]        WIN_LEN   = 4'(FILTER_LEN);
    localparam logic [DWIDTH-1:0] RST_COUNT = DWIDTH'(DEFAULT_COUNT);

    // Position of an {A,B} pair along the up-count cycle 00->01->11->10.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        logic [1:0] pos;
        case (ab)
            2'b00:   pos = 2'd0;
            2'b01:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    logic [1:0]        sync_a_q, sync_b_q;
    logic [1:0]        sample;

    state_t            state_q, state_d;
    logic [1:0]        cand_q, cand_d;
    logic [3:0]        win_cnt_q, win_cnt_d;
    logic [1:0]        ab_f_q, ab_f_d;
    logic [DWIDTH-1:0] count_q, count_d;
    logic              up_dwn_q, up_dwn_d;
    logic              step_q, step_d;
    logic              err_q, err_d;
    logic              sticky_q, sticky_d;

    logic              accept;
    logic [1:0]        delta;
    logic              step_req;
    logic              step_up;

    assign sample = {sync_a_q[1], sync_b_q[1]};

    // Two-flop synchronizers bringing qa/qb into the clk domain.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked branch and
        // the sensitivity list carries only the clock edge.
        if (!rst_n) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep the flop-to-flop shift
            // order-independent; blocking here would collapse the two stages.
            sync_a_q <= {sync_a_q[0], qa};
            sync_b_q <= {sync_b_q[0], qb};
        end
    end

    // Filter window, FSM next state, counter and error flag next-state logic.
    always_comb begin
        // NOTE: every output of this block is given a default first so that no
        // path leaves a variable unassigned, which would infer a latch.
        state_d   = state_q;
        cand_d    = cand_q;
        win_cnt_d = win_cnt_q;
        ab_f_d    = ab_f_q;
        count_d   = count_q;
        up_dwn_d  = up_dwn_q;
        step_d    = 1'b0;
        err_d     = 1'b0;
        sticky_d  = sticky_q;
        accept    = 1'b0;
        step_req  = 1'b0;
        step_up   = 1'b0;
        delta     = gray_pos(cand_q) - gray_pos(ab_f_q);

        // In INIT any stable value is accepted, even one equal to the reset
        // value of ab_f, so that tracking starts from the real input level.
        if (state_q == TRACK && sample == ab_f_q) begin
            cand_d    = sample;
            win_cnt_d = '0;
        end else if (sample != cand_q) begin
            cand_d    = sample;
            win_cnt_d = 4'd1;
        end else if (win_cnt_q == WIN_LEN) begin
            accept    = 1'b1;
            win_cnt_d = '0;
        end else begin
            win_cnt_d = win_cnt_q + 4'd1;
        end

        if (accept) begin
            ab_f_d = cand_q;
            if (state_q == INIT) begin
                state_d = TRACK;
            end else begin
                case (delta)
                    2'd1: begin
                        step_req = cntrl__ena;
                        step_up  = 1'b1;
                    end
                    2'd3: begin
                        step_req = cntrl__ena;
                        step_up  = 1'b0;
                    end
                    2'd2:    err_d = 1'b1;
                    default: ;
                endcase
            end
        end

        // Load wins over a same-cycle step; the step is dropped entirely.
        if (cntrl__load) begin
            count_d = cntrl__data_in;
        end else if (step_req) begin
            count_d  = step_up ? count_q + 1'b1 : count_q - 1'b1;
            up_dwn_d = step_up;
            step_d   = 1'b1;
        end

        // A fresh error outranks a clear request in the same cycle.
        if (err_d) begin
            sticky_d = 1'b1;
        end else if (err_clr) begin
            sticky_d = 1'b0;
        end
    end

    // State register for the FSM, filter, counter and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= INIT;
            cand_q    <= '0;
            win_cnt_q <= '0;
            ab_f_q    <= '0;
            count_q   <= RST_COUNT;
            up_dwn_q  <= 1'b1;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            win_cnt_q <= win_cnt_d;
            ab_f_q    <= ab_f_d;
            count_q   <= count_d;
            up_dwn_q  <= up_dwn_d;
            step_q    <= step_d;
            err_q     <= err_d;
            sticky_q  <= sticky_d;
        end
    end

    assign cntrl__up_dwn = up_dwn_q;
    assign step          = step_q;
    assign count         = count_q;
    assign err           = err_q;
    assign err_sticky    = sticky_q;

endmodule
